counter16_capture: RTL and testbench
====================================

# counter16_capture

Input-capture stage that sits directly downstream of the 16-bit free-running up counter. It watches an external event line, synchronises it to clock0, and detects the selected edge(s). On each detected edge it snapshots the counter value into a small first-word-fall-through FIFO, which a consumer drains over a valid/ready handshake. Its purpose is to timestamp events against the shared counter without losing back-to-back captures.

## Interface
- WIDTH, 16: counter/timestamp width.
- DEPTH, 4: FIFO entries; must be a power of two, ≥2.
- clock0  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- count  input  WIDTH  current counter value, in the clock0 domain.
- event_in  input  1  asynchronous event line.
- edge_sel  input  2  00 off, 01 rising, 10 falling, 11 both.
- cap_data  output  WIDTH  timestamp at the FIFO head.
- cap_valid  output  1  FIFO non-empty.
- cap_ready  input  1  consumer accepts the head entry.
- overflow  output  1  sticky; an event was dropped because the FIFO was full.
- clear_ovf  input  1  clears overflow.
- level  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- event_in passes through a 2-flop synchroniser (sync1 → sync2); prev holds the last value of sync2.
- Edge detection uses sync2 and prev:
  - rise = sync2 & ~prev
  - fall = ~sync2 & prev
  - hit = (edge_sel[0] & rise) | (edge_sel[1] & fall)
- edge_sel is combinational into hit. prev updates every cycle regardless of edge_sel.
- push = hit. pop = cap_valid & cap_ready.
- On push with the FIFO not full, or full with a simultaneous pop: write count, as sampled at that same clock edge, at the write pointer.
- On push with the FIFO full and no pop: drop the entry and set overflow. The FIFO contents are unchanged.
- Full with push and pop in the same cycle: both happen and level is unchanged.
- Empty with push: no bypass. cap_valid rises after the write edge.
- overflow: a set in the same cycle as clear_ovf wins. Otherwise clear_ovf clears it.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level = writes − reads, range 0..DEPTH.
- Timestamps are stored raw. Counter wrap (0xFFFF→0x0000) needs no special handling here; the consumer computes differences modulo 2^WIDTH.

## Timing
- Reset values:
  - sync1, sync2, prev = 0
  - pointers = 0, level = 0
  - cap_valid = 0, cap_data = 0, overflow = 0
  - FIFO memory is not reset
- A high event_in at reset release is treated as a rising edge once it has synchronised. This is intended.
- Latency:
  - event_in transition sampled at edge k: sync2 changes at k+1, and the FIFO write happens at edge k+2.
  - The stored value is count during cycle k+1 → k+2.
  - cap_valid rises after edge k+2 when the FIFO was empty.
- cap_data is the registered head entry, valid whenever cap_valid = 1. It holds stable while cap_valid & ~cap_ready.
- Sustained throughput: one capture per cycle (edge_sel = 11 with event_in toggling every cycle) with cap_ready held high.
- Reset mid-operation: all queued entries are discarded and overflow is cleared at the reset edge. An event in flight in the synchroniser is lost.

## Structure
- Package counter16_capture_pkg holds:
  - EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH (2-bit localparams)
  - the default WIDTH and DEPTH
- Sub-module counter16_capture_fifo is the FWFT FIFO. It takes WIDTH and DEPTH and has ports clock0, reset, push, wdata, pop, rdata, valid, full, level.
- The top level holds the synchroniser, edge detector and overflow flag.

## Test plan
- Single rising edge: edge_sel=01, count increments from 0x0010, and event_in rises at sample edge k → one entry equal to count at k+1, and cap_valid high after k+2.
- Both edges: edge_sel=11 with a 3-cycle-wide pulse → two entries whose difference is 3. edge_sel=00 with the same pulse → no entries.
- Overflow:
  - cap_ready=0, 5 rising edges, DEPTH=4 → level=4 and overflow=1.
  - The first 4 timestamps are retained in order.
  - clear_ovf → overflow=0.
  - clear_ovf in the same cycle as a dropped event → overflow stays 1.
- Full with simultaneous push and pop: level stays 4, the head advances, and the new timestamp is appended last.
- Wrap: count 0xFFFE..0x0001 with edges every cycle (edge_sel=11) → entries 0xFFFF, 0x0000 in order. Pointer wrap is checked over 10 push/pop cycles.
- Reset mid-operation: 3 entries queued and overflow=1, then reset for one cycle → cap_valid=0, level=0, overflow=0, and the next capture behaves normally.

Source files
------------

// File: rtl/counter16_capture_pkg.sv
// Shared constants for the counter16 input-capture stage: edge-select codes and
// default timestamp width / FIFO depth.
package counter16_capture_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH = 4;

endpackage

// File: rtl/counter16_capture_fifo.sv
// First-word-fall-through FIFO with a registered head entry; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module counter16_capture_fifo
  import counter16_capture_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clock0,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_rd_ptr_d;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_d;
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] w_head_d;
  logic             w_wr_en;
  logic             w_rd_en;

  assign full       = (r_level == LW'(DEPTH));
  assign valid      = (r_level != '0);
  assign level      = r_level;
  assign rdata      = r_rdata;
  assign w_rd_en    = pop & valid;
  assign w_wr_en    = push & (~full | w_rd_en);
  assign w_rd_ptr_d = r_rd_ptr + PW'(w_rd_en);

  always_comb begin
    w_level_d = r_level;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_level_d = r_level + LW'(1);
      2'b01:   w_level_d = r_level - LW'(1);
      default: w_level_d = r_level;
    endcase
  end

  // Next head comes straight from wdata when the slot being written becomes the head.
  always_comb begin
    w_head_d = r_mem[w_rd_ptr_d];
    if (w_wr_en && (r_wr_ptr == w_rd_ptr_d)) begin
      w_head_d = wdata;
    end
  end

  always_ff @(posedge clock0) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_ptr_d;
      r_level  <= w_level_d;
      if (w_level_d != '0) begin
        r_rdata <= w_head_d;
      end
    end
  end

endmodule

// File: rtl/counter16_capture.sv
// Input-capture top: synchronises event_in, detects the selected edges and queues
// counter timestamps, flagging events lost to a full queue.
module counter16_capture
  import counter16_capture_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clock0,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       count,
  input  logic                   event_in,
  input  logic [1:0]             edge_sel,
  output logic [WIDTH-1:0]       cap_data,
  output logic                   cap_valid,
  input  logic                   cap_ready,
  output logic                   overflow,
  input  logic                   clear_ovf,
  output logic [$clog2(DEPTH):0] level
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_ovf;
  logic w_rise;
  logic w_fall;
  logic w_hit;
  logic w_pop;
  logic w_full;
  logic w_drop;

  always_ff @(posedge clock0) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= event_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;
  assign w_hit  = (edge_sel[0] & w_rise) | (edge_sel[1] & w_fall);
  assign w_pop  = cap_valid & cap_ready;
  assign w_drop = w_hit & w_full & ~w_pop;

  // A drop in the same cycle as clear_ovf keeps the flag set.
  always_ff @(posedge clock0) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign overflow = r_ovf;

  counter16_capture_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock0 (clock0),
    .reset  (reset),
    .push   (w_hit),
    .wdata  (count),
    .pop    (w_pop),
    .rdata  (cap_data),
    .valid  (cap_valid),
    .full   (w_full),
    .level  (level)
  );

endmodule

// File: tb/tb_counter16_capture.sv
// Bench for counter16_capture: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed timestamps.
module tb_counter16_capture;
  import counter16_capture_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clock0 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] count = 16'h0000;
  logic        event_in = 1'b0;
  logic [1:0]  edge_sel = EDGE_OFF;
  logic [15:0] cap_data;
  logic        cap_valid;
  logic        cap_ready = 1'b0;
  logic        overflow;
  logic        clear_ovf = 1'b0;
  logic [2:0]  level;

  int n_chk = 0;
  int n_err = 0;

  counter16_capture #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) dut (
    .clock0    (clock0),
    .reset     (reset),
    .count     (count),
    .event_in  (event_in),
    .edge_sel  (edge_sel),
    .cap_data  (cap_data),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .overflow  (overflow),
    .clear_ovf (clear_ovf),
    .level     (level)
  );

  always #5 clock0 = ~clock0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: event samples indexed by edge number; an edge is seen two
  // edges after it is sampled, and the queue holds the timestamps.
  int          n_edge = 0;
  int          last_reset = -100;
  bit          ev_hist[int];
  logic [15:0] mq[$];
  bit          m_ovf = 1'b0;
  bit          m_started = 1'b0;

  function automatic bit ev_at(int m);
    if (m <= last_reset || !ev_hist.exists(m)) return 1'b0;
    return ev_hist[m];
  endfunction

  always @(posedge clock0) begin
    bit cur;
    bit old;
    bit hit;
    bit pop;
    bit drop;
    n_edge++;
    if (reset) begin
      ev_hist[n_edge] = 1'b0;
      last_reset = n_edge;
      mq.delete();
      m_ovf = 1'b0;
      m_started = 1'b1;
    end else begin
      ev_hist[n_edge] = event_in;
      cur  = ev_at(n_edge - 2);
      old  = ev_at(n_edge - 3);
      hit  = (edge_sel[0] && cur && !old) || (edge_sel[1] && !cur && old);
      pop  = (mq.size() > 0) && cap_ready;
      drop = hit && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (hit && !drop) mq.push_back(count);
      if (drop) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
    end
  end

  always @(negedge clock0) begin
    if (m_started) begin
      chk("model_level", 32'(level), 32'(mq.size()));
      chk("model_valid", 32'(cap_valid), 32'(mq.size() > 0));
      chk("model_ovf", 32'(overflow), 32'(m_ovf));
      if (mq.size() > 0) chk("model_data", 32'(cap_data), 32'(mq[0]));
    end
  end

  task automatic step();
    @(posedge clock0);
    #1;
    count = count + 16'd1;
  endtask

  task automatic pulses5();
    for (int i = 0; i < 5; i++) begin
      event_in = 1'b1;
      step();
      event_in = 1'b0;
      step();
    end
    repeat (3) step();
  endtask

  logic [15:0] head_a;
  logic [15:0] diff;
  logic [15:0] exp_q[4];

  initial begin
    repeat (3) step();
    chk("rst_valid", 32'(cap_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(cap_data), 32'd0);
    reset = 1'b0;
    step();

    // Single rising edge: sampled at k, written at k+2 with count 0x0012.
    edge_sel = EDGE_RISE;
    count = 16'h0010;
    event_in = 1'b1;
    step();
    step();
    chk("rise_not_yet", 32'(cap_valid), 32'd0);
    step();
    chk("rise_valid", 32'(cap_valid), 32'd1);
    chk("rise_data", 32'(cap_data), 32'h0012);
    chk("rise_level", 32'(level), 32'd1);
    cap_ready = 1'b1;
    step();
    cap_ready = 1'b0;
    chk("rise_drained", 32'(level), 32'd0);

    // Both edges of a 3-cycle pulse.
    event_in = 1'b0;
    repeat (3) step();
    edge_sel = EDGE_BOTH;
    event_in = 1'b1;
    repeat (3) step();
    event_in = 1'b0;
    repeat (4) step();
    chk("both_level", 32'(level), 32'd2);
    head_a = cap_data;
    cap_ready = 1'b1;
    step();
    cap_ready = 1'b0;
    diff = cap_data - head_a;
    chk("both_diff", 32'(diff), 32'd3);
    cap_ready = 1'b1;
    step();
    cap_ready = 1'b0;

    edge_sel = EDGE_OFF;
    event_in = 1'b1;
    repeat (3) step();
    event_in = 1'b0;
    repeat (4) step();
    chk("off_level", 32'(level), 32'd0);

    // Overflow: five rises into a depth-4 queue.
    edge_sel = EDGE_RISE;
    count = 16'h0100;
    pulses5();
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(cap_data), 32'h0102);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Drop on the same edge as clear_ovf: set wins.
    clear_ovf = 1'b1;
    event_in = 1'b1;
    step();
    step();
    chk("ovf_pre_drop", 32'(overflow), 32'd0);
    step();
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    step();
    chk("ovf_clear_after", 32'(overflow), 32'd0);
    clear_ovf = 1'b0;
    event_in = 1'b0;
    repeat (2) step();

    // Full with push and pop together.
    count = 16'h0200;
    event_in = 1'b1;
    step();
    step();
    cap_ready = 1'b1;
    step();
    cap_ready = 1'b0;
    chk("fullpp_level", 32'(level), 32'd4);
    chk("fullpp_head", 32'(cap_data), 32'h0104);
    chk("fullpp_ovf", 32'(overflow), 32'd0);
    event_in = 1'b0;
    repeat (2) step();

    exp_q[0] = 16'h0104;
    exp_q[1] = 16'h0106;
    exp_q[2] = 16'h0108;
    exp_q[3] = 16'h0202;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(cap_data), 32'(exp_q[i]));
      cap_ready = 1'b1;
      step();
      cap_ready = 1'b0;
    end
    chk("drain_empty", 32'(level), 32'd0);

    // Counter wrap.
    edge_sel = EDGE_BOTH;
    count = 16'hFFFD;
    event_in = 1'b1;
    step();
    event_in = 1'b0;
    repeat (3) step();
    chk("wrap_level", 32'(level), 32'd2);
    chk("wrap_first", 32'(cap_data), 32'h0000FFFF);
    cap_ready = 1'b1;
    step();
    cap_ready = 1'b0;
    chk("wrap_second", 32'(cap_data), 32'h00000000);
    cap_ready = 1'b1;
    step();

    // One capture per cycle with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      event_in = ~event_in;
      step();
    end
    chk("stream_level", 32'(level), 32'd1);
    repeat (3) step();
    chk("stream_done", 32'(level), 32'd0);
    cap_ready = 1'b0;

    // Reset mid-operation.
    edge_sel = EDGE_RISE;
    pulses5();
    cap_ready = 1'b1;
    step();
    cap_ready = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(cap_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    count = 16'h0300;
    event_in = 1'b1;
    repeat (3) step();
    chk("post_rst_valid", 32'(cap_valid), 32'd1);
    chk("post_rst_data", 32'(cap_data), 32'h0302);
    chk("post_rst_level", 32'(level), 32'd1);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
